iris_mem_stream_tx: RTL
=======================

# iris_mem_stream_tx

Memory-side streamer that feeds the 24-bit core data channel (`mem_axi_data_in`/`mem_axi_valid_in`/`mem_axi_ready_out` on each core). It accepts a burst command (base address and length) and reads words from a synchronous single-port RAM with 1-cycle read latency. It then delivers the words in order on a valid/ready stream, with a 2-entry output FIFO that absorbs backpressure without losing in-flight reads. It sits between the shared memory array and one core's memory input.

## Interface
- `DATA_WIDTH`, 24, stream/memory word width
- `ADDR_WIDTH`, 12, memory word-address width
- `LEN_WIDTH`, 12, burst length field width (max burst 2^LEN_WIDTH-1 words)

- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  burst command present
- `cmd_ready`  out  1  block can accept a command (IDLE only)
- `cmd_addr`  in  ADDR_WIDTH  first word address
- `cmd_len`  in  LEN_WIDTH  word count; 0 = empty burst
- `mem_rd_en`  out  1  memory read strobe
- `mem_rd_addr`  out  ADDR_WIDTH  read address
- `mem_rd_data`  in  DATA_WIDTH  read data, valid the cycle after `mem_rd_en`
- `out_data`  out  DATA_WIDTH  stream word (drives core `mem_axi_data_in`)
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  consumer ready (core `mem_axi_ready_out`)
- `out_last`  out  1  qualifies final word of burst
- `busy`  out  1  burst in progress (state != IDLE)
- `done`  out  1  one-cycle pulse at burst completion

## Operation
- FSM has three states.
  - IDLE: `cmd_ready`=1. When `cmd_valid` is 1, latch `cmd_addr` into the address counter and `cmd_len` into the remaining-issue and remaining-deliver counters. Go to RUN, or to FIN if `cmd_len`=0.
  - RUN: issue reads and deliver words. When the remaining-deliver counter reaches 0 (last word handshaken), go to FIN.
  - FIN: `done`=1 for exactly one cycle, then IDLE.
- Read issue rule: assert `mem_rd_en` in a cycle iff state=RUN, issue counter > 0, and fifo_count + inflight − pop < 2.
  - inflight = registered copy of the previous cycle's `mem_rd_en`.
  - pop = `out_valid` && `out_ready`.
- On each issue: `mem_rd_addr` = address counter. The counter then increments modulo 2^ADDR_WIDTH (wraps from all-ones to 0). The issue counter decrements.
- Read return: when inflight=1, `mem_rd_data` is written to the FIFO tail at the end of that cycle. The credit rule guarantees no overflow; an overflow is a design error and the bench asserts it never occurs.
- Output side:
  - `out_data` and `out_valid` come from the FIFO head.
  - `out_last` = `out_valid` && remaining-deliver counter = 1.
  - Each pop decrements the deliver counter.
  - While `out_valid` && !`out_ready`, `out_data` and `out_last` hold stable.
- Simultaneous FIFO write and pop: count unchanged, data order preserved.
- New commands are not accepted until FIN → IDLE. `cmd_valid` during RUN/FIN is ignored, with no latching.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `cmd_ready`=0, `mem_rd_en`=0, `mem_rd_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0.
  - FIFO empty, counters 0, state IDLE.
  - `cmd_ready` rises at the first clock edge after reset release.
- Command handshake in cycle C0 gives:
  - `busy`=1 from C1.
  - First `mem_rd_en` in C1 with `mem_rd_addr`=`cmd_addr`.
  - Data captured at the end of C2.
  - `out_valid`=1 in C3.
  - First-word latency is 3 cycles.
- With `out_ready` held at 1, throughput is one word per cycle. A burst of N words completes its last handshake in cycle C(N+2).
- `done` is high in the cycle after the last handshake. `busy` drops and `cmd_ready` rises in the cycle after that.
- `cmd_len`=0 handshake in C0: `done` is high in C1, `cmd_ready`=1 in C2, and `mem_rd_en` never asserts.
- Reset asserted mid-burst:
  - All state is cleared immediately; in-flight read data is discarded.
  - No `done` pulse is produced.
  - Memory contents are untouched.

## Test plan
- Reset values: all outputs 0 during reset, then `cmd_ready`=1 one edge after release.
- Basic burst: memory[i]=i+0x100; `cmd_addr`=0x010, `cmd_len`=4, `out_ready`=1.
  - Required: `out_data` 0x110, 0x111, 0x112, 0x113 on consecutive cycles starting C3.
  - `out_last` set only on 0x113; `done` high one cycle later.
- Backpressure: same burst with `out_ready` toggling 1,0,0,1,…
  - Required: all 4 words delivered in order, none lost or duplicated, `out_data` stable while stalled.
  - No more than 2 reads outstanding (fifo_count + inflight ≤ 2) at any time.
- Address wrap: `cmd_addr`=0xFFE, `cmd_len`=4.
  - Required: `mem_rd_addr` sequence is 0xFFE, 0xFFF, 0x000, 0x001.
- Empty burst: `cmd_len`=0.
  - Required: no `mem_rd_en`, `done` pulses in C1, `out_valid` stays 0.
- Mid-burst reset: `cmd_len`=8, `rst_n` dropped after 3 words delivered.
  - Required: outputs go to reset values immediately and there is no `done` pulse.
  - A new burst of 2 words after release streams correctly from its own `cmd_addr`.

Source files
------------

// File: rtl/iris_mem_stream_tx.sv
// Burst read streamer: RAM (1-cycle latency) to valid/ready stream.
// Two-entry output FIFO with read credits so backpressure never drops data.
module iris_mem_stream_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_e;

  state_e                  state_q, state_d;
  logic                    init_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    iss_q;
  logic [LEN_WIDTH-1:0]    dlv_q;
  logic                    infl_q;
  logic [1:0]              cnt_q;
  logic [DATA_WIDTH-1:0]   head_q;
  logic [DATA_WIDTH-1:0]   tail_q;

  logic                    cmd_fire;
  logic                    pop;
  logic                    push;
  logic [2:0]              occ;
  logic                    credit_ok;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign out_last  = out_valid && (dlv_q == LEN_WIDTH'(1));
  assign pop       = out_valid && out_ready;
  assign push      = infl_q;
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign mem_rd_addr = addr_q;

  // Slots already claimed: buffered words plus the read returning now.
  assign occ       = {1'b0, cnt_q} + {2'b00, infl_q};
  assign credit_ok = occ < (3'd2 + {2'b00, pop});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (cmd_fire)
                state_d = (cmd_len == '0) ? S_FIN : S_RUN;
      S_RUN:  if (pop && dlv_q == LEN_WIDTH'(1))
                state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE) && init_q;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_FIN);
    mem_rd_en = (state_q == S_RUN) && (iss_q != '0) && credit_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      iss_q  <= '0;
      dlv_q  <= '0;
      infl_q <= 1'b0;
    end else begin
      infl_q <= mem_rd_en;
      if (cmd_fire) begin
        addr_q <= cmd_addr;
        iss_q  <= cmd_len;
        dlv_q  <= cmd_len;
      end else begin
        if (mem_rd_en) begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          iss_q  <= iss_q - LEN_WIDTH'(1);
        end
        if (pop)
          dlv_q <= dlv_q - LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= mem_rd_data;
          else               tail_q <= mem_rd_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= mem_rd_data;
          end else begin
            head_q <= tail_q;
            tail_q <= mem_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
